// File: rtl/lcd_stream_ctrl.sv
// lcd_stream_ctrl: HD44780 4-bit LCD controller. It runs the power-on init and
// configuration sequence, then streams command/data bytes from a valid/ready
// port to the LCD pins as two timed nibbles per byte.
//
// Handshake: a byte is transferred on a rising Clock edge where iValid && oReady.
// oReady is high only in ST_IDLE. iValid while oReady is low is ignored (not
// queued). iRS/iData are copied on acceptance, so later changes have no effect.
module lcd_stream_ctrl #(
  parameter int T_40NS_CYC   = 2,
  parameter int T_230NS_CYC  = 12,
  parameter int T_1US_CYC    = 50,
  parameter int T_40US_CYC   = 2000,
  parameter int T_100US_CYC  = 5000,
  parameter int T_1_64MS_CYC = 82000,
  parameter int T_4_1MS_CYC  = 205000,
  parameter int T_15MS_CYC   = 750000,
  parameter int CNT_W        = 20
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iValid,
  input  logic       iRS,
  input  logic [7:0] iData,
  output logic       oReady,
  output logic       oInitDone,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [3:0] SF_D,
  output logic       SF_CE0,
  output logic [2:0] oDbgState
);

  typedef enum logic [2:0] {
    ST_PWR_WAIT = 3'd0,
    ST_INIT     = 3'd1,
    ST_CFG      = 3'd2,
    ST_IDLE     = 3'd3,
    ST_WR_HI    = 3'd4,
    ST_WR_GAP   = 3'd5,
    ST_WR_LO    = 3'd6,
    ST_WR_WAIT  = 3'd7
  } state_t;

  // Timer value at which LCD_E falls; follow-on waits are counted from here.
  localparam int E_FALL = T_40NS_CYC + T_230NS_CYC;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [2:0]       init_idx_q, init_idx_d;
  logic [1:0]       cfg_idx_q, cfg_idx_d;
  logic             cfg_lo_q, cfg_lo_d;
  logic             wr_rs_q, wr_rs_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic             done_q, done_d;
  logic             e_q, e_d;
  logic             lcd_rs_q, lcd_rs_d;
  logic [3:0]       sfd_q, sfd_d;
  logic             ready_q, ready_d;
  logic             in_pulse;
  logic [7:0]       cfg_b;

  // Timer value of the last cycle of an interval n cycles long.
  function automatic logic [CNT_W-1:0] last_tick(input int n);
    return CNT_W'(n - 1);
  endfunction

  function automatic int init_wait(input logic [2:0] idx);
    case (idx)
      3'd0:    return T_4_1MS_CYC;
      3'd1:    return T_100US_CYC;
      default: return T_40US_CYC;
    endcase
  endfunction

  function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h28;
      2'd1:    return 8'h06;
      2'd2:    return 8'h0C;
      default: return 8'h01;
    endcase
  endfunction

  // Clear and home commands need the long execution wait.
  function automatic int byte_wait(input logic rs, input logic [7:0] b);
    if (!rs && (b == 8'h01 || b == 8'h02 || b == 8'h03)) return T_1_64MS_CYC;
    return T_40US_CYC;
  endfunction

  // State register plus every registered output.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_PWR_WAIT;
      timer_q    <= '0;
      init_idx_q <= '0;
      cfg_idx_q  <= '0;
      cfg_lo_q   <= 1'b0;
      wr_rs_q    <= 1'b0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      e_q        <= 1'b0;
      lcd_rs_q   <= 1'b0;
      sfd_q      <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      init_idx_q <= init_idx_d;
      cfg_idx_q  <= cfg_idx_d;
      cfg_lo_q   <= cfg_lo_d;
      wr_rs_q    <= wr_rs_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
      e_q        <= e_d;
      lcd_rs_q   <= lcd_rs_d;
      sfd_q      <= sfd_d;
      ready_q    <= ready_d;
    end
  end

  // Next-state logic: sequencing, saturating timer, init/config indices, byte latch.
  always_comb begin
    state_d    = state_q;
    timer_d    = (timer_q == CNT_MAX) ? timer_q : timer_q + CNT_ONE;
    init_idx_d = init_idx_q;
    cfg_idx_d  = cfg_idx_q;
    cfg_lo_d   = cfg_lo_q;
    wr_rs_d    = wr_rs_q;
    wr_data_d  = wr_data_q;
    done_d     = done_q;
    case (state_q)
      ST_PWR_WAIT: begin
        if (timer_q == last_tick(T_15MS_CYC)) begin
          state_d    = ST_INIT;
          timer_d    = '0;
          init_idx_d = '0;
        end
      end
      ST_INIT: begin
        if (timer_q == last_tick(E_FALL + init_wait(init_idx_q))) begin
          timer_d = '0;
          if (init_idx_q == 3'd3) begin
            state_d   = ST_CFG;
            cfg_idx_d = '0;
            cfg_lo_d  = 1'b0;
          end else begin
            init_idx_d = init_idx_q + 3'd1;
          end
        end
      end
      ST_CFG: begin
        if (!cfg_lo_q) begin
          if (timer_q == last_tick(E_FALL + T_1US_CYC)) begin
            timer_d  = '0;
            cfg_lo_d = 1'b1;
          end
        end else if (timer_q == last_tick(E_FALL + byte_wait(1'b0, cfg_byte(cfg_idx_q)))) begin
          timer_d  = '0;
          cfg_lo_d = 1'b0;
          if (cfg_idx_q == 2'd3) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            cfg_idx_d = cfg_idx_q + 2'd1;
          end
        end
      end
      ST_IDLE: begin
        if (iValid && ready_q) begin
          state_d   = ST_WR_HI;
          timer_d   = '0;
          wr_rs_d   = iRS;
          wr_data_d = iData;
        end
      end
      ST_WR_HI: begin
        if (timer_q == last_tick(E_FALL)) begin
          state_d = ST_WR_GAP;
          timer_d = '0;
        end
      end
      ST_WR_GAP: begin
        if (timer_q == last_tick(T_1US_CYC)) begin
          state_d = ST_WR_LO;
          timer_d = '0;
        end
      end
      ST_WR_LO: begin
        if (timer_q == last_tick(E_FALL)) begin
          state_d = ST_WR_WAIT;
          timer_d = '0;
        end
      end
      ST_WR_WAIT: begin
        if (timer_q == last_tick(byte_wait(wr_rs_q, wr_data_q))) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end
      end
      default: begin
        state_d = ST_PWR_WAIT;
        timer_d = '0;
        done_d  = 1'b0;
      end
    endcase
  end

  // Output logic: next values of the pins, derived from the next state and timer.
  always_comb begin
    e_d      = 1'b0;
    sfd_d    = sfd_q;
    lcd_rs_d = lcd_rs_q;
    ready_d  = 1'b0;
    cfg_b    = cfg_byte(cfg_idx_d);
    in_pulse = (timer_d >= CNT_W'(T_40NS_CYC)) && (timer_d < CNT_W'(E_FALL));
    case (state_d)
      ST_PWR_WAIT: begin
        sfd_d    = '0;
        lcd_rs_d = 1'b0;
      end
      ST_INIT: begin
        sfd_d    = (init_idx_d == 3'd3) ? 4'h2 : 4'h3;
        lcd_rs_d = 1'b0;
        e_d      = in_pulse;
      end
      ST_CFG: begin
        sfd_d    = cfg_lo_d ? cfg_b[3:0] : cfg_b[7:4];
        lcd_rs_d = 1'b0;
        e_d      = in_pulse;
      end
      ST_IDLE: ready_d = 1'b1;
      ST_WR_HI: begin
        sfd_d    = wr_data_d[7:4];
        lcd_rs_d = wr_rs_d;
        e_d      = in_pulse;
      end
      ST_WR_LO: begin
        sfd_d    = wr_data_d[3:0];
        lcd_rs_d = wr_rs_d;
        e_d      = in_pulse;
      end
      default: ;
    endcase
  end

  assign LCD_E     = e_q;
  assign LCD_RS    = lcd_rs_q;
  assign SF_D      = sfd_q;
  assign oReady    = ready_q;
  assign oInitDone = done_q;
  assign LCD_RW    = 1'b0;
  assign SF_CE0    = 1'b1;
  assign oDbgState = state_q;

endmodule

// File: tb/tb_lcd_stream_ctrl.sv
// tb_lcd_stream_ctrl: randomized byte stream against a pulse-level reference
// model of the LCD bus (nibble, RS, placement delay, E width, ready timing).
module tb_lcd_stream_ctrl;

  localparam int T_40NS  = 2;
  localparam int T_230NS = 12;
  localparam int T_1US   = 50;
  localparam int T_40US  = 100;
  localparam int T_100US = 200;
  localparam int T_164MS = 400;
  localparam int T_41MS  = 300;
  localparam int T_15MS  = 500;
  localparam int LIMIT   = 5000;

  localparam logic [1:0] REF_REL  = 2'd0;  // measured from reset release
  localparam logic [1:0] REF_FALL = 2'd1;  // measured from previous E fall
  localparam logic [1:0] REF_ACC  = 2'd2;  // measured from byte acceptance

  typedef struct packed {
    logic        rs;
    logic [3:0]  nib;
    logic [1:0]  kind;
    logic [19:0] delay;
    logic        done;
  } pulse_t;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       iValid = 1'b0;
  logic       iRS = 1'b0;
  logic [7:0] iData = 8'h00;
  logic       oReady, oInitDone, LCD_E, LCD_RS, LCD_RW, SF_CE0;
  logic [3:0] SF_D;
  logic [2:0] oDbgState;

  pulse_t      exp_q[$];
  logic [19:0] wait_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc;

  lcd_stream_ctrl #(
    .T_40NS_CYC(T_40NS), .T_230NS_CYC(T_230NS), .T_1US_CYC(T_1US),
    .T_40US_CYC(T_40US), .T_100US_CYC(T_100US), .T_1_64MS_CYC(T_164MS),
    .T_4_1MS_CYC(T_41MS), .T_15MS_CYC(T_15MS), .CNT_W(20)
  ) dut (
    .Clock(Clock), .Reset(Reset), .iValid(iValid), .iRS(iRS), .iData(iData),
    .oReady(oReady), .oInitDone(oInitDone), .LCD_E(LCD_E), .LCD_RS(LCD_RS),
    .LCD_RW(LCD_RW), .SF_D(SF_D), .SF_CE0(SF_CE0), .oDbgState(oDbgState)
  );

  // Clock and cycle counter (posedges since reset release)
  always #5 Clock = ~Clock;

  always @(posedge Clock or posedge Reset) begin
    if (Reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model
  function automatic int wait_for(input logic rs, input logic [7:0] b);
    if (rs == 1'b0 && b >= 8'h01 && b <= 8'h03) return T_164MS;
    return T_40US;
  endfunction

  function automatic void push_pulse(input logic rs, input logic [3:0] nib,
                                     input logic [1:0] kind, input int d, input logic done);
    pulse_t p;
    p.rs = rs; p.nib = nib; p.kind = kind; p.delay = 20'(d); p.done = done;
    exp_q.push_back(p);
  endfunction

  function automatic void push_init_seq();
    logic [3:0] init_nib[4];
    int         init_w[4];
    logic [7:0] cfg[4];
    int         w_prev;
    init_nib = '{4'h3, 4'h3, 4'h3, 4'h2};
    init_w   = '{T_41MS, T_100US, T_40US, T_40US};
    cfg      = '{8'h28, 8'h06, 8'h0C, 8'h01};
    push_pulse(1'b0, init_nib[0], REF_REL, T_15MS + T_40NS, 1'b0);
    for (int i = 1; i < 4; i++)
      push_pulse(1'b0, init_nib[i], REF_FALL, init_w[i-1] + T_40NS, 1'b0);
    w_prev = init_w[3];
    for (int i = 0; i < 4; i++) begin
      push_pulse(1'b0, cfg[i][7:4], REF_FALL, w_prev + T_40NS, 1'b0);
      push_pulse(1'b0, cfg[i][3:0], REF_FALL, T_1US + T_40NS, 1'b0);
      w_prev = wait_for(1'b0, cfg[i]);
    end
    wait_q.push_back(20'(w_prev));
  endfunction

  // Driver: waits for oReady (injecting ignored iValid noise), then offers one byte
  task automatic send(input logic rs, input logic [7:0] d);
    int n;
    n = 0;
    @(posedge Clock); #1;
    while (oReady !== 1'b1 && n < LIMIT) begin
      iValid = 1'($urandom_range(0, 1));
      iRS    = 1'($urandom_range(0, 1));
      iData  = 8'($urandom_range(0, 255));
      @(posedge Clock); #1;
      n++;
    end
    check("ready_within_limit", {31'd0, oReady}, 32'd1);
    if (oReady === 1'b1) begin
      iValid = 1'b1; iRS = rs; iData = d;
      push_pulse(rs, d[7:4], REF_ACC, T_40NS, 1'b1);
      push_pulse(rs, d[3:0], REF_FALL, T_1US + T_40NS, 1'b1);
      wait_q.push_back(20'(wait_for(rs, d)));
      @(posedge Clock); #1;
      iValid = 1'b0;
      iRS    = ~rs;
      iData  = ~d ^ 8'($urandom_range(0, 255));
    end else begin
      iValid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || wait_q.size() != 0) && n < LIMIT) begin
      @(negedge Clock);
      n++;
    end
    check("expectations_drained", 32'(exp_q.size() + wait_q.size()), 32'd0);
  endtask

  task automatic check_reset_values();
    check("rst_lcd_e", {31'd0, LCD_E}, 32'd0);
    check("rst_lcd_rs", {31'd0, LCD_RS}, 32'd0);
    check("rst_sf_d", {28'd0, SF_D}, 32'd0);
    check("rst_ready", {31'd0, oReady}, 32'd0);
    check("rst_init_done", {31'd0, oInitDone}, 32'd0);
    check("lcd_rw_tied", {31'd0, LCD_RW}, 32'd0);
    check("sf_ce0_tied", {31'd0, SF_CE0}, 32'd1);
  endtask

  // Scoreboard monitor: samples on the falling edge
  logic        m_prev_e, m_prev_rdy, m_chk_low, m_rs;
  logic [3:0]  m_nib;
  int          m_rise_n, m_fall_n, m_acc_n, m_ref;
  pulse_t      m_p;
  logic [19:0] m_w;

  initial begin
    m_prev_e = 1'b0; m_prev_rdy = 1'b0; m_chk_low = 1'b0; m_rs = 1'b0; m_nib = '0;
    m_rise_n = 0; m_fall_n = 0; m_acc_n = 0; m_ref = 0;
    forever begin
      @(negedge Clock);
      if (Reset) begin
        m_prev_e = 1'b0; m_prev_rdy = 1'b0; m_chk_low = 1'b0;
        m_fall_n = 0; m_acc_n = 0;
      end else begin
        if (LCD_E && !m_prev_e) begin
          m_rise_n = cyc; m_nib = SF_D; m_rs = LCD_RS;
          if (exp_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_pulse: E pulse with SF_D=%0h RS=%0d, none expected (cycle %0d)",
                     SF_D, LCD_RS, cyc);
          end else begin
            m_p = exp_q.pop_front();
            m_ref = (m_p.kind == REF_FALL) ? m_fall_n : (m_p.kind == REF_ACC) ? m_acc_n : 0;
            check("pulse_nibble", {28'd0, SF_D}, {28'd0, m_p.nib});
            check("pulse_rs", {31'd0, LCD_RS}, {31'd0, m_p.rs});
            check("pulse_delay", 32'(cyc - m_ref), {12'd0, m_p.delay});
            check("init_done_at_pulse", {31'd0, oInitDone}, {31'd0, m_p.done});
          end
        end else if (LCD_E && m_prev_e) begin
          check("bus_stable_while_e", {27'd0, SF_D, LCD_RS}, {27'd0, m_nib, m_rs});
        end
        if (!LCD_E && m_prev_e) begin
          check("pulse_width", 32'(cyc - m_rise_n), 32'(T_230NS));
          m_fall_n = cyc;
        end
        if (oReady && !m_prev_rdy) begin
          if (wait_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_ready: oReady rose with no byte pending (cycle %0d)", cyc);
          end else begin
            m_w = wait_q.pop_front();
            check("ready_wait", 32'(cyc - m_fall_n), {12'd0, m_w});
            check("init_done_at_ready", {31'd0, oInitDone}, 32'd1);
          end
        end
        if (m_chk_low) check("ready_drop_after_accept", {31'd0, oReady}, 32'd0);
        m_chk_low = iValid && oReady;
        if (iValid && oReady) m_acc_n = cyc + 1;
        m_prev_e   = LCD_E;
        m_prev_rdy = oReady;
      end
    end
  end

  // Stimulus and final report
  initial begin
    int n;
    logic r;
    logic [7:0] d;
    repeat (3) @(negedge Clock);
    check_reset_values();
    push_init_seq();
    Reset = 1'b0;

    send(1'b1, 8'h41);
    send(1'b0, 8'h01);
    send(1'b0, 8'h80);
    send(1'b0, 8'h02);
    send(1'b1, 8'h03);
    for (int i = 0; i < 12; i++) begin
      r = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) d = 8'($urandom_range(1, 3));
      else                           d = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 3)) @(posedge Clock);
      send(r, d);
    end
    drain();
    repeat (300) @(negedge Clock);

    // Reset in the middle of a byte, while E is high
    send(1'b1, 8'h5A);
    n = 0;
    while (LCD_E !== 1'b1 && n < LIMIT) begin
      @(negedge Clock);
      n++;
    end
    check("e_high_before_reset", {31'd0, LCD_E}, 32'd1);
    #2;
    Reset = 1'b1;
    exp_q.delete();
    wait_q.delete();
    #1;
    check("async_reset_e", {31'd0, LCD_E}, 32'd0);
    check("async_reset_ready", {31'd0, oReady}, 32'd0);
    check("async_reset_done", {31'd0, oInitDone}, 32'd0);
    repeat (3) @(negedge Clock);
    check_reset_values();
    push_init_seq();
    Reset = 1'b0;
    send(1'b1, 8'h33);
    send(1'b0, 8'h01);
    drain();
    repeat (100) @(negedge Clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
